// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, responder state type and byte-lane mask helper
package dmem_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;
   // halfword lanes ignore off[0] and words ignore off entirely (force-aligned)
   function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
      return f3[1:0] == 2'b00 ? 4'b0001 << off :
             f3[1:0] == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) :
             f3[1:0] == 2'b10 ? 4'b1111 : 4'b0000;
   endfunction
endpackage

// File: rtl/dmem_if.sv
// dmem_if: load/store request and response handshakes between datapath (master) and memory (slave)
//   req_valid/req_ready, req_addr, req_we, req_funct3, req_wdata
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err
interface dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   modport master (output req_valid, req_addr, req_we, req_funct3, req_wdata, rsp_ready,
                   input  req_ready, rsp_valid, rsp_rdata, rsp_err);
   modport slave  (input  req_valid, req_addr, req_we, req_funct3, req_wdata, rsp_ready,
                   output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for stores and extraction/extension for loads
//   in : f3 (funct3), off (addr[1:0]), wdata (store data), rword (addressed memory word)
//   out: wmask (byte-lane write enables), wdata_sh (lane-replicated store data), ld_data (extended load)
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  f3,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  wmask,
   output logic [31:0] wdata_sh,
   output logic [31:0] ld_data
);
   logic [7:0]  b;
   logic [15:0] h;
   assign wmask = lane_mask(f3, off);
   // replicating the narrow datum across all lanes lets the mask pick the target lane
   assign wdata_sh = f3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                     f3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
   assign b = rword[{off, 3'b000} +: 8];
   assign h = off[1] ? rword[31:16] : rword[15:0];
   assign ld_data = f3 == F3_B  ? {{24{b[7]}}, b} :
                    f3 == F3_BU ? {24'b0, b} :
                    f3 == F3_H  ? {{16{h[15]}}, h} :
                    f3 == F3_HU ? {16'b0, h} :
                    f3 == F3_W  ? rword : 32'b0;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: latency-modelled data memory with RISC-V B/H/W load/store semantics
//   clk, reset (sync, active-high); bus: dmem_if.slave request/response handshakes
//   DEPTH_WORDS: memory size in 32-bit words (power of two); LATENCY: cycles spent in BUSY (>=1)
//   DMEM_MISALIGN_TRAP_EN: when defined, misaligned H/HU/W accesses report rsp_err instead of force-aligning
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
)(
   input logic   clk,
   input logic   reset,
   dmem_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(LATENCY + 1);
   state_t          state, state_n;
   logic [CW-1:0]   cnt;
   logic [AW-1:0]   a_idx;
   logic [1:0]      a_off;
   logic            a_we;
   logic [2:0]      a_f3;
   logic [31:0]     a_wdata;
   logic [31:0]     mem [DEPTH_WORDS];
   logic [31:0]     rdata_q;
   logic            err_q;
   logic [3:0]      wmask;
   logic [31:0]     wdata_sh, ld_data;
   logic            accept, commit, illegal, misalign, err;

   assign bus.req_ready = state == ST_IDLE;
   assign bus.rsp_valid = state == ST_RESP;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

   always_ff @(posedge clk)
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= accept ? CW'(LATENCY - 1) : state == ST_BUSY ? cnt - 1'b1 : cnt;
      end

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      commit  = 1'b0;
      case (state)
         ST_IDLE: if (bus.req_valid) begin
            accept  = 1'b1;
            state_n = ST_BUSY;
         end
         ST_BUSY: if (cnt == '0) begin
            commit  = 1'b1;
            state_n = ST_RESP;
         end
         ST_RESP: if (bus.rsp_ready) state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk)
      if (accept) begin
         a_idx   <= bus.req_addr[AW+1:2];
         a_off   <= bus.req_addr[1:0];
         a_we    <= bus.req_we;
         a_f3    <= bus.req_funct3;
         a_wdata <= bus.req_wdata;
      end

   // unsupported codes 011/110/111, and stores never take the unsigned encodings
   assign illegal = a_f3 == 3'b011 || a_f3[2:1] == 2'b11 || (a_we && a_f3[2]);
`ifdef DMEM_MISALIGN_TRAP_EN
   assign misalign = (a_f3[1:0] == 2'b01 && a_off[0]) || (a_f3[1:0] == 2'b10 && a_off != 2'b00);
`else
   assign misalign = 1'b0;
`endif
   assign err = illegal || misalign;

   dmem_lane_align u_align (
      .f3      (a_f3),
      .off     (a_off),
      .wdata   (a_wdata),
      .rword   (mem[a_idx]),
      .wmask   (wmask),
      .wdata_sh(wdata_sh),
      .ld_data (ld_data)
   );

   always_ff @(posedge clk)
      if (reset) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (commit) begin
         rdata_q <= (err || a_we) ? 32'b0 : ld_data;
         err_q   <= err;
      end

   // contents are not reset; a reset on the commit edge drops the store
   always_ff @(posedge clk)
      if (commit && a_we && !err && !reset)
         for (int i = 0; i < 4; i++)
            if (wmask[i]) mem[a_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (LATENCY=2, DEPTH_WORDS=256)
module tb_dmem_responder;
   import dmem_pkg::*;
   logic clk = 0;
   logic reset = 1;
   int checks = 0;
   int failures = 0;
   logic [32:0] exp_q[$];
   string tag_q[$];

   dmem_if bus();
   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   always @(negedge clk)
      if (!reset && bus.rsp_valid && bus.rsp_ready) begin
         if (exp_q.size() == 0) chk("unexpected rsp", 32'd1, 32'd0);
         else begin
            logic [32:0] e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk({t, " data"}, bus.rsp_rdata, e[31:0]);
            chk({t, " err"}, {31'b0, bus.rsp_err}, {31'b0, e[32]});
         end
      end

   task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      bus.req_valid  = 1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
   endtask

   // waits for acceptance (left at posedge+#1 of E0), bounded
   task automatic wait_accept(input string tag);
      int n = 0;
      logic acc = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = bus.req_ready;
         @(posedge clk);
         n++;
      end
      #1 bus.req_valid = 0;
      if (!acc) chk({tag, " accept timeout"}, 32'd0, 32'd1);
   endtask

   task automatic xact(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] ed, input logic ee);
      int n = 0;
      exp_q.push_back({ee, ed});
      tag_q.push_back(tag);
      drive_req(we, f3, addr, wd);
      wait_accept(tag);
      do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 50);
      chk({tag, " latency"}, n, 32'd3);
      n = 0;
      while (bus.rsp_valid && n < 50) begin @(negedge clk); n++; end
      if (bus.rsp_valid) chk({tag, " rsp timeout"}, 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] v;
      int n;
      bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0; bus.req_addr = 0; bus.req_wdata = 0;
      bus.rsp_ready = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst req_ready", {31'b0, bus.req_ready}, 32'd1);
      chk("rst rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      chk("rst rdata", bus.rsp_rdata, 32'd0);
      chk("rst err", {31'b0, bus.rsp_err}, 32'd0);
      @(posedge clk); #1 reset = 0;

      xact("sw10",  1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0, 0);
      xact("lw10",  0, F3_W,  32'h10, 32'h0, 32'hDEADBEEF, 0);
      xact("sb13",  1, F3_B,  32'h13, 32'h12345680, 32'h0, 0);
      xact("lb13",  0, F3_B,  32'h13, 32'h0, 32'hFFFFFF80, 0);
      xact("lbu13", 0, F3_BU, 32'h13, 32'h0, 32'h00000080, 0);
      xact("lw10b", 0, F3_W,  32'h10, 32'h0, 32'h80ADBEEF, 0);
      xact("lh12",  0, F3_H,  32'h12, 32'h0, 32'hFFFF80AD, 0);
      xact("lhu12", 0, F3_HU, 32'h12, 32'h0, 32'h000080AD, 0);
      xact("sw14",  1, F3_W,  32'h14, 32'h0, 32'h0, 0);
      xact("sh14",  1, F3_H,  32'h14, 32'h12347FFE, 32'h0, 0);
      xact("lw14",  0, F3_W,  32'h14, 32'h0, 32'h00007FFE, 0);
      xact("lb15",  0, F3_B,  32'h15, 32'h0, 32'h0000007F, 0);

      // backpressure: response held while a second request waits
      bus.rsp_ready = 0;
      exp_q.push_back({1'b0, 32'h80ADBEEF}); tag_q.push_back("bp lw");
      drive_req(0, F3_W, 32'h10, 32'h0);
      wait_accept("bp lw");
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 50);
      chk("bp latency", n, 32'd3);
      v = bus.rsp_rdata;
      @(posedge clk); #1;
      exp_q.push_back({1'b0, 32'h00000080}); tag_q.push_back("bp lbu");
      drive_req(0, F3_BU, 32'h13, 32'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp valid", {31'b0, bus.rsp_valid}, 32'd1);
         chk("bp stable", bus.rsp_rdata, v);
         chk("bp req_ready", {31'b0, bus.req_ready}, 32'd0);
      end
      @(posedge clk); #1 bus.rsp_ready = 1;
      @(negedge clk);
      @(negedge clk);
      chk("bp after hs req_ready", {31'b0, bus.req_ready}, 32'd1);
      chk("bp after hs valid", {31'b0, bus.rsp_valid}, 32'd0);
      @(negedge clk);
      chk("bp accepted", {31'b0, bus.req_ready}, 32'd0);
      bus.req_valid = 0;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 50);
      chk("bp2 latency", n, 32'd2);
      @(negedge clk);
      @(posedge clk); #1;

`ifdef DMEM_MISALIGN_TRAP_EN
      xact("lw11",  0, F3_W,  32'h11, 32'h0, 32'h0, 1);
`else
      xact("lw11",  0, F3_W,  32'h11, 32'h0, 32'h80ADBEEF, 0);
`endif
      xact("f3_011", 0, 3'b011, 32'h10, 32'h0, 32'h0, 1);
      xact("st111",  1, 3'b111, 32'h10, 32'hFFFFFFFF, 32'h0, 1);
      xact("st100",  1, F3_BU,  32'h10, 32'h0, 32'h0, 1);
      xact("lw10c",  0, F3_W,  32'h10, 32'h0, 32'h80ADBEEF, 0);
      xact("wrap",   0, F3_W,  32'h410, 32'h0, 32'h80ADBEEF, 0);
      xact("sw20",   1, F3_W,  32'h20, 32'hCAFEF00D, 32'h0, 0);

      // reset before the commit edge drops the store
      drive_req(1, F3_W, 32'h20, 32'h12345678);
      wait_accept("rst sw");
      reset = 1;
      @(posedge clk); #1 reset = 0;
      @(negedge clk);
      chk("midrst req_ready", {31'b0, bus.req_ready}, 32'd1);
      chk("midrst valid", {31'b0, bus.rsp_valid}, 32'd0);
      repeat (3) @(negedge clk);
      chk("midrst idle", {31'b0, bus.rsp_valid}, 32'd0);
      @(posedge clk); #1;
      xact("lw20",   0, F3_W,  32'h20, 32'h0, 32'hCAFEF00D, 0);

      repeat (3) @(posedge clk);
      chk("scoreboard empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
